axi4_axi4lite_conv: RTL and testbench

Bridges an AXI4 (burst) slave port to an AXI4-Lite master port. It is the reverse of the SoC's AXI4-Lite-to-AXI4 bridge. It sits between an AXI4 interconnect master port and AXI4-Lite-only peripherals. Each AXI4 burst is split into len+1 single-beat AXI4-Lite transactions with burst-correct addressing. Write and read paths are independent FSMs, each with one outstanding burst.

---
 rtl/axi4_axi4lite_conv.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_axi4lite_conv.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_axi4lite_conv.sv
// axi4_axi4lite_conv: splits AXI4 bursts into single-beat AXI4-Lite transactions
module axi4_axi4lite_conv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_awvalid_i,
  output logic        inport_awready_o,
  input  logic [31:0] inport_awaddr_i,
  input  logic [3:0]  inport_awid_i,
  input  logic [7:0]  inport_awlen_i,
  input  logic [1:0]  inport_awburst_i,
  input  logic        inport_wvalid_i,
  output logic        inport_wready_o,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  input  logic        inport_wlast_i,
  output logic        inport_bvalid_o,
  input  logic        inport_bready_i,
  output logic [1:0]  inport_bresp_o,
  output logic [3:0]  inport_bid_o,
  input  logic        inport_arvalid_i,
  output logic        inport_arready_o,
  input  logic [31:0] inport_araddr_i,
  input  logic [3:0]  inport_arid_i,
  input  logic [7:0]  inport_arlen_i,
  input  logic [1:0]  inport_arburst_i,
  output logic        inport_rvalid_o,
  input  logic        inport_rready_i,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic [3:0]  inport_rid_o,
  output logic        inport_rlast_o,
  output logic        outport_awvalid_o,
  input  logic        outport_awready_i,
  output logic [31:0] outport_awaddr_o,
  output logic        outport_wvalid_o,
  input  logic        outport_wready_i,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  input  logic        outport_bvalid_i,
  output logic        outport_bready_o,
  input  logic [1:0]  outport_bresp_i,
  output logic        outport_arvalid_o,
  input  logic        outport_arready_i,
  output logic [31:0] outport_araddr_o,
  input  logic        outport_rvalid_i,
  output logic        outport_rready_o,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i
);
  typedef enum logic [2:0] {W_IDLE, W_DATA, W_ISSUE, W_RESP, W_BRESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_OUT} rstate_t;

  // Beat address advance for 4-byte beats; WRAP with an illegal length degrades to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] mask;
    logic        wrap_ok;
    mask    = {22'd0, len, 2'b11};
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b00) ? a :
           (burst == 2'b10 && wrap_ok) ? ((a & ~mask) | ((a + 32'd4) & mask)) : a + 32'd4;
  endfunction

  wstate_t     wstate_q, wstate_d;
  logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d;
  logic [3:0]  wid_q, wid_d, wstrb_q, wstrb_d;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]  wburst_q, wburst_d, wresp_q, wresp_d;
  logic        awv_q, awv_d, wv_q, wv_d;

  rstate_t     rstate_q, rstate_d;
  logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
  logic [3:0]  rid_q, rid_d;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]  rburst_q, rburst_d, rresp_q, rresp_d;

  // Write path: accept AW, then per beat take one W, issue Lite AW+W, collect Lite B and merge.
  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wid_d    = wid_q;
    wstrb_d  = wstrb_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    wburst_d = wburst_q;
    wresp_d  = wresp_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    case (wstate_q)
      W_IDLE: if (inport_awvalid_i) begin
        waddr_d  = inport_awaddr_i;
        wid_d    = inport_awid_i;
        wlen_d   = inport_awlen_i;
        wburst_d = inport_awburst_i;
        wcnt_d   = 8'd0;
        wresp_d  = 2'b00;
        wstate_d = W_DATA;
      end
      W_DATA: if (inport_wvalid_i) begin
        wdata_d  = inport_wdata_i;
        wstrb_d  = inport_wstrb_i;
        awv_d    = 1'b1;
        wv_d     = 1'b1;
        wstate_d = W_ISSUE;
      end
      W_ISSUE: begin
        awv_d    = awv_q & ~outport_awready_i;
        wv_d     = wv_q & ~outport_wready_i;
        wstate_d = (!awv_d && !wv_d) ? W_RESP : W_ISSUE;
      end
      W_RESP: if (outport_bvalid_i) begin
        wresp_d  = (wresp_q == 2'b00) ? outport_bresp_i : wresp_q;
        wcnt_d   = (wcnt_q == wlen_q) ? wcnt_q : wcnt_q + 8'd1;
        waddr_d  = (wcnt_q == wlen_q) ? waddr_q : next_addr(waddr_q, wlen_q, wburst_q);
        wstate_d = (wcnt_q == wlen_q) ? W_BRESP : W_DATA;
      end
      W_BRESP: if (inport_bready_i) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read path: accept AR, then per beat issue Lite AR, capture Lite R, present it upstream.
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rburst_d = rburst_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: if (inport_arvalid_i) begin
        raddr_d  = inport_araddr_i;
        rid_d    = inport_arid_i;
        rlen_d   = inport_arlen_i;
        rburst_d = inport_arburst_i;
        rcnt_d   = 8'd0;
        rstate_d = R_ADDR;
      end
      R_ADDR: if (outport_arready_i) rstate_d = R_DATA;
      R_DATA: if (outport_rvalid_i) begin
        rdata_d  = outport_rdata_i;
        rresp_d  = outport_rresp_i;
        rstate_d = R_OUT;
      end
      R_OUT: if (inport_rready_i) begin
        rcnt_d   = (rcnt_q == rlen_q) ? rcnt_q : rcnt_q + 8'd1;
        raddr_d  = (rcnt_q == rlen_q) ? raddr_q : next_addr(raddr_q, rlen_q, rburst_q);
        rstate_d = (rcnt_q == rlen_q) ? R_IDLE : R_ADDR;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // State and payload registers for both paths.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wid_q    <= '0;
      wstrb_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wburst_q <= '0;
      wresp_q  <= '0;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rburst_q <= '0;
      rresp_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wid_q    <= wid_d;
      wstrb_q  <= wstrb_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wburst_q <= wburst_d;
      wresp_q  <= wresp_d;
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rburst_q <= rburst_d;
      rresp_q  <= rresp_d;
    end
  end

  assign inport_awready_o  = wstate_q == W_IDLE;
  assign inport_wready_o   = wstate_q == W_DATA;
  assign inport_bvalid_o   = wstate_q == W_BRESP;
  assign inport_bresp_o    = wresp_q;
  assign inport_bid_o      = wid_q;
  assign outport_awvalid_o = awv_q;
  assign outport_awaddr_o  = waddr_q;
  assign outport_wvalid_o  = wv_q;
  assign outport_wdata_o   = wdata_q;
  assign outport_wstrb_o   = wstrb_q;
  assign outport_bready_o  = wstate_q == W_RESP;
  assign inport_arready_o  = rstate_q == R_IDLE;
  assign outport_arvalid_o = rstate_q == R_ADDR;
  assign outport_araddr_o  = raddr_q;
  assign outport_rready_o  = rstate_q == R_DATA;
  assign inport_rvalid_o   = rstate_q == R_OUT;
  assign inport_rdata_o    = rdata_q;
  assign inport_rresp_o    = rresp_q;
  assign inport_rid_o      = rid_q;
  assign inport_rlast_o    = (rstate_q == R_OUT) && (rcnt_q == rlen_q);
endmodule

// File: tb/tb_axi4_axi4lite_conv.sv
// tb_axi4_axi4lite_conv: scoreboard bench with a Lite slave model and directed bursts
module tb_axi4_axi4lite_conv;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inport_awvalid_i = 0, inport_wvalid_i = 0, inport_wlast_i = 0, inport_bready_i = 1;
  logic        inport_arvalid_i = 0, inport_rready_i = 1;
  logic [31:0] inport_awaddr_i = 0, inport_wdata_i = 0, inport_araddr_i = 0;
  logic [3:0]  inport_awid_i = 0, inport_wstrb_i = 0, inport_arid_i = 0;
  logic [7:0]  inport_awlen_i = 0, inport_arlen_i = 0;
  logic [1:0]  inport_awburst_i = 0, inport_arburst_i = 0;
  logic        outport_awready_i = 1, outport_wready_i = 1, outport_bvalid_i = 0;
  logic        outport_arready_i = 1, outport_rvalid_i = 0;
  logic [1:0]  outport_bresp_i = 0, outport_rresp_i = 0;
  logic [31:0] outport_rdata_i = 0;
  logic        inport_awready_o, inport_wready_o, inport_bvalid_o, inport_arready_o;
  logic        inport_rvalid_o, inport_rlast_o, outport_awvalid_o, outport_wvalid_o;
  logic        outport_bready_o, outport_arvalid_o, outport_rready_o;
  logic [1:0]  inport_bresp_o, inport_rresp_o;
  logic [3:0]  inport_bid_o, inport_rid_o, outport_wstrb_o;
  logic [31:0] inport_rdata_o, outport_awaddr_o, outport_wdata_o, outport_araddr_o;

  int checks = 0, errors = 0, aw_stall = 0;
  logic [31:0] exp_aw[$], exp_ar[$];
  logic [35:0] exp_w[$];
  logic [38:0] exp_r[$];
  logic [5:0]  exp_b[$];
  logic [1:0]  bresp_q[$];

  axi4_axi4lite_conv dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport_awvalid_i(inport_awvalid_i), .inport_awready_o(inport_awready_o),
    .inport_awaddr_i(inport_awaddr_i), .inport_awid_i(inport_awid_i),
    .inport_awlen_i(inport_awlen_i), .inport_awburst_i(inport_awburst_i),
    .inport_wvalid_i(inport_wvalid_i), .inport_wready_o(inport_wready_o),
    .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i), .inport_wlast_i(inport_wlast_i),
    .inport_bvalid_o(inport_bvalid_o), .inport_bready_i(inport_bready_i),
    .inport_bresp_o(inport_bresp_o), .inport_bid_o(inport_bid_o),
    .inport_arvalid_i(inport_arvalid_i), .inport_arready_o(inport_arready_o),
    .inport_araddr_i(inport_araddr_i), .inport_arid_i(inport_arid_i),
    .inport_arlen_i(inport_arlen_i), .inport_arburst_i(inport_arburst_i),
    .inport_rvalid_o(inport_rvalid_o), .inport_rready_i(inport_rready_i),
    .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
    .inport_rid_o(inport_rid_o), .inport_rlast_o(inport_rlast_o),
    .outport_awvalid_o(outport_awvalid_o), .outport_awready_i(outport_awready_i),
    .outport_awaddr_o(outport_awaddr_o),
    .outport_wvalid_o(outport_wvalid_o), .outport_wready_i(outport_wready_i),
    .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
    .outport_bvalid_i(outport_bvalid_i), .outport_bready_o(outport_bready_o),
    .outport_bresp_i(outport_bresp_i),
    .outport_arvalid_o(outport_arvalid_o), .outport_arready_i(outport_arready_i),
    .outport_araddr_o(outport_araddr_o),
    .outport_rvalid_i(outport_rvalid_i), .outport_rready_o(outport_rready_o),
    .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [1:0] rd_resp(input logic [31:0] a);
    return (a[3:2] == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s", name);
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL unexpected %s handshake", name);
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [3:0] id, input logic last);
    exp_ar.push_back(a);
    exp_r.push_back({id, last, rd_resp(a), rd_val(a)});
  endtask

  // Lite slave: B after both AW and W, R one cycle after AR; optional AW stall counted while AW is pending.
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, ar_pend;
    logic [31:0] ar_a;
    got_aw = 0; got_w = 0; ar_pend = 0; ar_a = 0;
    forever begin
      @(negedge clk_i);
      aw_hs = outport_awvalid_o && outport_awready_i;
      w_hs  = outport_wvalid_o && outport_wready_i;
      b_hs  = outport_bvalid_i && outport_bready_o;
      ar_hs = outport_arvalid_o && outport_arready_i;
      r_hs  = outport_rvalid_i && outport_rready_o;
      if (ar_hs) ar_a = outport_araddr_o;
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        got_aw = 0; got_w = 0; ar_pend = 0;
        outport_bvalid_i = 0; outport_rvalid_i = 0;
      end else begin
        if (aw_hs) got_aw = 1;
        if (w_hs) got_w = 1;
        if (b_hs) outport_bvalid_i = 0;
        if (got_aw && got_w && !outport_bvalid_i) begin
          outport_bvalid_i = 1;
          outport_bresp_i = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
          got_aw = 0; got_w = 0;
        end
        if (ar_hs) ar_pend = 1;
        if (r_hs) outport_rvalid_i = 0;
        if (ar_pend && !outport_rvalid_i) begin
          outport_rvalid_i = 1;
          outport_rdata_i = rd_val(ar_a);
          outport_rresp_i = rd_resp(ar_a);
          ar_pend = 0;
        end
      end
      if (aw_stall > 0 && outport_awvalid_o) aw_stall--;
      outport_awready_i = (aw_stall == 0);
    end
  end

  // Monitor: pops expected entries on every handshake and checks held payload stability.
  initial begin
    bit aw_hold = 0, r_hold = 0;
    logic [31:0] aw_prev = 0;
    logic [32:0] r_prev = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        aw_hold = 0; r_hold = 0;
      end else begin
        if (outport_awvalid_o && outport_awready_i) begin
          if (exp_aw.size() == 0) unexp("lite_aw");
          else chk("lite_aw", 64'(outport_awaddr_o), 64'(exp_aw.pop_front()));
        end
        if (outport_wvalid_o && outport_wready_i) begin
          if (exp_w.size() == 0) unexp("lite_w");
          else chk("lite_w", 64'({outport_wdata_o, outport_wstrb_o}), 64'(exp_w.pop_front()));
        end
        if (outport_arvalid_o && outport_arready_i) begin
          if (exp_ar.size() == 0) unexp("lite_ar");
          else chk("lite_ar", 64'(outport_araddr_o), 64'(exp_ar.pop_front()));
        end
        if (inport_rvalid_o && inport_rready_i) begin
          if (exp_r.size() == 0) unexp("in_r");
          else chk("in_r", 64'({inport_rid_o, inport_rlast_o, inport_rresp_o, inport_rdata_o}), 64'(exp_r.pop_front()));
        end
        if (inport_bvalid_o && inport_bready_i) begin
          if (exp_b.size() == 0) unexp("in_b");
          else chk("in_b", 64'({inport_bid_o, inport_bresp_o}), 64'(exp_b.pop_front()));
        end
        if (aw_hold && outport_awvalid_o) chk("awaddr_stable", 64'(outport_awaddr_o), 64'(aw_prev));
        if (r_hold && inport_rvalid_o) chk("rdata_stable", 64'({inport_rlast_o, inport_rdata_o}), 64'(r_prev));
        aw_hold = outport_awvalid_o && !outport_awready_i;
        aw_prev = outport_awaddr_o;
        r_hold  = inport_rvalid_o && !inport_rready_i;
        r_prev  = {inport_rlast_o, inport_rdata_o};
      end
    end
  end

  task automatic axi_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    inport_awvalid_i = 1; inport_awaddr_i = a; inport_awid_i = id;
    inport_awlen_i = len; inport_awburst_i = burst;
    do begin @(negedge clk_i); t++; end while (!inport_awready_o && t < 200);
    if (!inport_awready_o) tmo("aw");
    @(posedge clk_i); #1 inport_awvalid_i = 0;
  endtask

  task automatic axi_wbeat(input logic [31:0] d, input logic [3:0] s, input logic last);
    int t = 0;
    inport_wvalid_i = 1; inport_wdata_i = d; inport_wstrb_i = s; inport_wlast_i = last;
    exp_w.push_back({d, s});
    do begin @(negedge clk_i); t++; end while (!inport_wready_o && t < 200);
    if (!inport_wready_o) tmo("w");
    @(posedge clk_i); #1 inport_wvalid_i = 0;
  endtask

  task automatic axi_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    inport_arvalid_i = 1; inport_araddr_i = a; inport_arid_i = id;
    inport_arlen_i = len; inport_arburst_i = burst;
    do begin @(negedge clk_i); t++; end while (!inport_arready_o && t < 200);
    if (!inport_arready_o) tmo("ar");
    @(posedge clk_i); #1 inport_arvalid_i = 0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] dbase, input logic [1:0] resp);
    int t = 0;
    axi_aw(a, id, len, burst);
    for (int i = 0; i <= int'(len); i++) axi_wbeat(dbase + i, i[0] ? 4'h3 : 4'hF, i == int'(len));
    exp_b.push_back({id, resp});
    do begin @(negedge clk_i); t++; end while (!(inport_bvalid_o && inport_bready_i) && t < 200);
    if (!(inport_bvalid_o && inport_bready_i)) tmo("b");
    @(posedge clk_i); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int rstall);
    int t = 0;
    if (rstall > 0) inport_rready_i = 0;
    axi_ar(a, id, len, burst);
    if (rstall > 0) begin
      do begin @(negedge clk_i); t++; end while (!inport_rvalid_o && t < 200);
      if (!inport_rvalid_o) tmo("r_stall");
      repeat (rstall) @(posedge clk_i);
      #1 inport_rready_i = 1;
    end
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      do begin @(negedge clk_i); t++; end while (!(inport_rvalid_o && inport_rready_i) && t < 200);
      if (!(inport_rvalid_o && inport_rready_i)) tmo("r");
      @(posedge clk_i); #1;
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valids"}, 64'({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o,
        inport_bvalid_o, inport_rvalid_o, inport_rlast_o}), 64'(0));
    chk({name, "_readys"}, 64'({inport_awready_o, inport_arready_o}), 64'(2'b11));
  endtask

  initial begin
    #1 rst_i = 0;
    repeat (2) @(negedge clk_i);
    chk_idle("reset");
    @(posedge clk_i); #1 rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1;

    exp_aw.push_back(32'h100);
    axi_write(32'h100, 4'h3, 8'd0, 2'b01, 32'hDEAD_BEEF, 2'b00);

    exp_aw.push_back(32'h2000); exp_aw.push_back(32'h2004);
    exp_aw.push_back(32'h2008); exp_aw.push_back(32'h200C);
    axi_write(32'h2000, 4'hA, 8'd3, 2'b01, 32'h1111_0000, 2'b00);

    exp_rd(32'h1008, 4'h5, 0); exp_rd(32'h100C, 4'h5, 0);
    exp_rd(32'h1000, 4'h5, 0); exp_rd(32'h1004, 4'h5, 1);
    axi_read(32'h1008, 4'h5, 8'd3, 2'b10, 0);

    bresp_q.push_back(2'b00); bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b11); bresp_q.push_back(2'b00);
    exp_aw.push_back(32'h3004); exp_aw.push_back(32'h3008);
    exp_aw.push_back(32'h300C); exp_aw.push_back(32'h3000);
    axi_write(32'h3004, 4'h6, 8'd3, 2'b10, 32'h3333_0000, 2'b10);

    exp_rd(32'h7008, 4'h1, 0); exp_rd(32'h700C, 4'h1, 0); exp_rd(32'h7010, 4'h1, 1);
    axi_read(32'h7008, 4'h1, 8'd2, 2'b10, 0);
    exp_rd(32'hFFFF_FFFC, 4'h2, 0); exp_rd(32'h0000_0000, 4'h2, 1);
    axi_read(32'hFFFF_FFFC, 4'h2, 8'd1, 2'b11, 0);

    aw_stall = 5;
    exp_aw.push_back(32'h400);
    axi_write(32'h400, 4'h7, 8'd0, 2'b01, 32'hCAFE_F00D, 2'b00);
    exp_rd(32'h80C, 4'h9, 1);
    axi_read(32'h80C, 4'h9, 8'd0, 2'b01, 3);

    for (int i = 0; i < 4; i++) exp_aw.push_back(32'h6000);
    for (int i = 0; i < 8; i++) exp_rd(32'h5000 + 4 * i, 4'hC, i == 7);
    fork
      axi_write(32'h6000, 4'h2, 8'd3, 2'b00, 32'h6666_0000, 2'b00);
      axi_read(32'h5000, 4'hC, 8'd7, 2'b01, 0);
    join

    exp_aw.push_back(32'h9000);
    axi_aw(32'h9000, 4'h4, 8'd3, 2'b01);
    axi_wbeat(32'h9999_0000, 4'hF, 0);
    inport_rready_i = 0;
    exp_ar.push_back(32'hA000);
    axi_ar(32'hA000, 4'h8, 8'd7, 2'b01);
    repeat (6) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    chk_idle("midreset");
    chk("midreset_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'(0));
    @(posedge clk_i); #1 rst_i = 1; inport_rready_i = 1;
    @(negedge clk_i);
    chk_idle("post_reset");
    @(posedge clk_i); #1;

    exp_aw.push_back(32'hB000);
    axi_write(32'hB000, 4'hE, 8'd0, 2'b01, 32'h0BAD_CAFE, 2'b00);
    repeat (4) @(posedge clk_i);
    chk("scoreboard_empty", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size() + exp_b.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
